outport_buffer: RTL and testbench

Output port for the CPU datapath, the outbound counterpart of the input port register. The control unit strobes a bus value into a small FIFO. The FIFO drains to an external device over a valid/ready handshake, so the CPU can issue several port writes back-to-back without waiting on a slow peripheral. Status flags (full, empty, count, sticky overflow) are exported so that software can poll before writing.

---
 rtl/outport_buffer.sv | 121 ++++++++++++
 tb/tb_outport_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/outport_buffer.sv
// outport_buffer: CPU output port. Control-unit strobes are queued in a small
// FIFO that drains to an external device over a valid/ready handshake.
// Status flags (full/empty/count/sticky overflow) are registered for polling.
module outport_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       Outport_in,
  input  logic [DATA_WIDTH-1:0]      BusMuxOut,
  input  logic                       ext_ready,
  output logic                       ext_valid,
  output logic [DATA_WIDTH-1:0]      ext_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PW-1:0]         wp, rp, wp_nxt, rp_nxt, rp_inc;
  logic [CW-1:0]         count_nxt;
  logic                  full_nxt, empty_nxt, ovf_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  push, pop, drop;
  occ_e                  occ;

  // Handshake is purely registered: valid comes from the empty flop only.
  assign ext_valid = !empty;
  assign pop       = ext_valid && ext_ready;
  assign push      = Outport_in && (!full || pop);
  assign drop      = Outport_in && full && !pop;
  assign rp_inc    = rp + 1'b1;

  // Occupancy class derived from the registered count.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0)             occ = OCC_EMPTY;
    else if (count == CW'(DEPTH)) occ = OCC_FULL;
  end

  // Next-state: pointers, count, flags and the head-of-queue output stage.
  always_comb begin
    wp_nxt    = wp;
    rp_nxt    = rp;
    count_nxt = count;
    data_nxt  = ext_data;
    ovf_nxt   = overflow;

    if (push) wp_nxt = wp + 1'b1;
    if (pop)  rp_nxt = rp_inc;

    unique case (occ)
      OCC_EMPTY: begin
        if (push) count_nxt = count + 1'b1;
      end
      OCC_PARTIAL: begin
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (pop && !push) count_nxt = count - 1'b1;
      end
      OCC_FULL: begin
        if (pop && !push) count_nxt = count - 1'b1;
      end
      default: count_nxt = count;
    endcase

    // Head changes: a push into an empty queue, or a pop leaving entries.
    // When the last entry pops while a new one arrives, the new head is the
    // incoming bus value (its memory slot is only written on this edge).
    if (push && (occ == OCC_EMPTY || (pop && count == CW'(1))))
      data_nxt = BusMuxOut;
    else if (pop && count > CW'(1))
      data_nxt = mem[rp_inc];

    // Drop wins over a same-cycle clear.
    if (drop)         ovf_nxt = 1'b1;
    else if (ovf_clr) ovf_nxt = 1'b0;

    full_nxt  = (count_nxt == CW'(DEPTH));
    empty_nxt = (count_nxt == '0);
  end

  // State registers; asynchronous clear puts outputs at reset values at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      ext_data <= INIT;
    end else begin
      wp       <= wp_nxt;
      rp       <= rp_nxt;
      count    <= count_nxt;
      full     <= full_nxt;
      empty    <= empty_nxt;
      overflow <= ovf_nxt;
      ext_data <= data_nxt;
    end
  end

  // Storage array; contents after reset are don't-care, so no reset here.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= BusMuxOut;
  end

endmodule

// File: tb/tb_outport_buffer.sv
// Self-checking bench for outport_buffer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_outport_buffer;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] INIT  = 32'hA5A5_0001;

  logic          clock, clear, Outport_in, ext_ready, ovf_clr;
  logic [DW-1:0] BusMuxOut;
  logic          ext_valid, full, empty, overflow;
  logic [DW-1:0] ext_data;
  logic [2:0]    count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic [31:0] mdata;
  logic        movf;

  outport_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .clock(clock), .clear(clear), .Outport_in(Outport_in), .BusMuxOut(BusMuxOut),
    .ext_ready(ext_ready), .ext_valid(ext_valid), .ext_data(ext_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdata = INIT;
    movf  = 1'b0;
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".valid"}, 32'(ext_valid), 32'(q.size() != 0));
    chk({tag, ".data"},  ext_data, mdata);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"},  32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(overflow), 32'(movf));
  endtask

  task automatic drive(input logic w, input logic [31:0] d, input logic r, input logic c);
    Outport_in = w;
    BusMuxOut  = d;
    ext_ready  = r;
    ovf_clr    = c;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    bit pop, push;
    logic [31:0] tmp;
    @(posedge clock);
    if (!clear) model_reset();
    else begin
      pop  = (q.size() != 0) && ext_ready;
      push = Outport_in && ((q.size() < DEPTH) || pop);
      if (pop)  tmp = q.pop_front();
      if (push) q.push_back(BusMuxOut);
      if (Outport_in && !push) movf = 1'b1;
      else if (ovf_clr)        movf = 1'b0;
      if (q.size() != 0) mdata = q[0];
    end
    #1;
    cmp_all(tag);
  endtask

  initial begin
    clear = 1'b0;
    drive(0, '0, 0, 0);
    model_reset();
    #12;
    cmp_all("reset");
    clear = 1'b1;
    #2;

    // Single write, held while not ready, then popped.
    drive(1, 32'hDEADBEEF, 0, 0); step("single");
    chk("single.head", ext_data, 32'hDEADBEEF);
    drive(0, '0, 0, 0);
    repeat (5) step("hold");
    drive(0, '0, 1, 0); step("pop1");
    drive(0, '0, 0, 0); step("after_pop");
    chk("single.kept", ext_data, 32'hDEADBEEF);

    // Fill, drop, drain.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'(i), 0, 0); step("fill");
    end
    chk("fill.ovf", 32'(overflow), 32'd1);
    drive(0, '0, 1, 0);
    repeat (5) step("drain");

    // Full with simultaneous push/pop.
    drive(0, '0, 0, 1); step("clr");
    for (int i = 10; i <= 13; i++) begin
      drive(1, 32'(i), 0, 0); step("fill2");
    end
    drive(1, 32'd14, 1, 0); step("fullpp");
    chk("fullpp.count", 32'(count), 32'd4);
    drive(0, '0, 1, 0);
    repeat (5) step("drain2");

    // Streaming through several pointer wraps.
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'(i), 1, 0); step("stream");
      chk("stream.seq", ext_data, 32'(i));
    end
    drive(0, '0, 1, 0); step("stream_end");

    // Overflow clear priority.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100 + 32'(i), 0, 0); step("fill3");
    end
    drive(1, 32'h200, 0, 1); step("clr_vs_drop");
    chk("clr_vs_drop.ovf", 32'(overflow), 32'd1);
    drive(0, '0, 0, 1); step("clr_alone");
    chk("clr_alone.ovf", 32'(overflow), 32'd0);
    drive(0, '0, 1, 0);
    repeat (4) step("drain3");

    // Random traffic in phases with varying write/ready pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 100; n++) begin
        drive($urandom_range(0, 3) > 32'(ph % 2), $urandom,
              $urandom_range(0, 3) > 32'(ph / 2 + 1) || ph == 3 && n[0],
              $urandom_range(0, 15) == 0);
        step("rand");
      end
    end

    // Asynchronous reset mid-operation with three entries queued.
    drive(0, '0, 0, 1); step("pre");
    drive(0, '0, 1, 0); step("pre");
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC0 + 32'(i), 0, 0); step("pre3");
    end
    drive(1, 32'hEE, 0, 0); step("pre_full");
    drive(1, 32'hEF, 0, 0); step("pre_ovf");
    drive(0, '0, 1, 0); step("pre_pop");
    chk("pre.count", 32'(count), 32'd3);
    drive(0, '0, 0, 0);
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    cmp_all("async_rst");
    chk("async_rst.data", ext_data, INIT);
    drive(1, 32'h55, 1, 0);
    step("in_rst");
    clear = 1'b1;
    drive(1, 32'h77, 0, 0); step("post_rst");
    chk("post_rst.data", ext_data, 32'h77);
    for (int n = 0; n < 40; n++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 0);
      step("rand2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
